// File: rtl/corr_accum32_pkg.sv
// corr_pkg: shared correlator widths, accumulate FSM states and saturating add
package corr_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, CLEAR} state_t;
  localparam int DATA_W = 8;
  localparam int LAGS = 32;
  localparam int ACC_W = 32;
  localparam int CNT_W = 32;
  localparam int SAT_W = 64;
  // Returns {saturated, value}; value is clamped to 2^w-1 (w < SAT_W).
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a, input logic [SAT_W-1:0] b, input int unsigned w);
    logic [SAT_W:0] s, m, one;
    one = (SAT_W+1)'(1);
    s = {1'b0, a} + {1'b0, b};
    m = (one << w) - one;
    return (s > m) ? {1'b1, m[SAT_W-1:0]} : {1'b0, s[SAT_W-1:0]};
  endfunction
endpackage

// File: rtl/corr_accum32_if.sv
// corr_accum32_if: sample/history/readout/status bundle of the lag-bin accumulator
interface corr_accum32_if #(
  parameter int DATA_W = corr_pkg::DATA_W,
  parameter int AW = $clog2(corr_pkg::LAGS),
  parameter int ACC_W = corr_pkg::ACC_W,
  parameter int CNT_W = corr_pkg::CNT_W
);
  logic clr, cur_load, hist_valid, hist_last, rd_en;
  logic [DATA_W-1:0] cur_data, hist_data;
  logic [AW-1:0] rd_addr;
  logic [ACC_W-1:0] rd_data;
  logic rd_valid, busy, ovf, proto_err;
  logic [CNT_W-1:0] sample_cnt;
  modport master(output clr, cur_load, cur_data, hist_valid, hist_data, hist_last, rd_en, rd_addr,
                 input rd_data, rd_valid, busy, sample_cnt, ovf, proto_err);
  modport slave(input clr, cur_load, cur_data, hist_valid, hist_data, hist_last, rd_en, rd_addr,
                output rd_data, rd_valid, busy, sample_cnt, ovf, proto_err);
endinterface

// File: rtl/corr_accum32_bin_ram.sv
// corr_bin_ram: LAGS x ACC_W bin store, one write port and one registered read port
module corr_bin_ram #(
  parameter int AW = 5,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [ACC_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [ACC_W-1:0] rdata_o
);
  logic [ACC_W-1:0] mem_q [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/corr_accum32.sv
// corr_accum32: per-lag multiply-accumulate of current sample against streamed history
module corr_accum32 #(
  parameter int DATA_W = corr_pkg::DATA_W,
  parameter int LAGS = corr_pkg::LAGS,
  parameter int AW = $clog2(LAGS),
  parameter int ACC_W = corr_pkg::ACC_W,
  parameter int CNT_W = corr_pkg::CNT_W
) (
  input logic          clk,
  input logic          rst_n,
  corr_accum32_if.slave bus
);
  import corr_pkg::*;
  localparam logic [AW:0] LAST_BIN = (AW+1)'(LAGS-1);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  state_t state_q, state_d;
  logic [AW:0] lag_q, lag_d;
  logic [DATA_W-1:0] cur_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [AW-1:0] a1_q, ra, wa;
  logic v1_q, l1_q, rd_valid_q, ovf_q, perr_q;
  logic [CNT_W-1:0] cnt_q;
  logic beat, beat_ok, last, rd_go, clr_wr, acc_wr, we;
  logic [ACC_W-1:0] rdat, wd;
  logic [SAT_W:0] sum;
  always_comb begin
    beat = bus.hist_valid & ~bus.clr & (state_q != CLEAR);
    beat_ok = beat & ~lag_q[AW];
    last = beat & bus.hist_last;
    rd_go = bus.rd_en & (state_q == IDLE) & ~bus.clr & ~bus.hist_valid;
    clr_wr = state_q == CLEAR;
    acc_wr = v1_q & ~bus.clr & ~clr_wr;
    we = clr_wr | acc_wr;
    ra = beat ? lag_q[AW-1:0] : bus.rd_addr;
    wa = clr_wr ? lag_q[AW-1:0] : a1_q;
    sum = sat_add(SAT_W'(rdat), SAT_W'(prod_q), ACC_W);
    wd = clr_wr ? '0 : sum[ACC_W-1:0];
    state_d = bus.clr ? CLEAR
            : state_q == IDLE ? (bus.hist_valid ? ACCUM : IDLE)
            : state_q == ACCUM ? ((l1_q & ~beat) ? IDLE : ACCUM)
            : (lag_q == LAST_BIN) ? IDLE : CLEAR;
    // lag_q doubles as the sweep address while clearing; it saturates at LAGS in a long burst
    lag_d = (bus.clr | (clr_wr & (lag_q == LAST_BIN))) ? '0
          : clr_wr ? lag_q + ONE
          : last ? '0
          : (beat & ~lag_q[AW]) ? lag_q + ONE
          : lag_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lag_q <= '0;
      cur_q <= '0;
      prod_q <= '0;
      a1_q <= '0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      rd_valid_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lag_q <= lag_d;
      cur_q <= (bus.cur_load & ~bus.clr & (state_q == IDLE)) ? bus.cur_data : cur_q;
      prod_q <= (2*DATA_W)'(cur_q) * (2*DATA_W)'(bus.hist_data);
      a1_q <= lag_q[AW-1:0];
      v1_q <= beat_ok;
      l1_q <= last;
      rd_valid_q <= rd_go;
      cnt_q <= bus.clr ? '0 : cnt_q + CNT_W'(last);
      ovf_q <= ~bus.clr & (ovf_q | (acc_wr & sum[SAT_W]));
      perr_q <= ~bus.clr & (perr_q | (beat & lag_q[AW]));
    end
  end
  corr_bin_ram #(.AW(AW), .ACC_W(ACC_W)) u_ram (
    .clk(clk), .we_i(we), .waddr_i(wa), .wdata_i(wd), .raddr_i(ra), .rdata_o(rdat)
  );
  assign bus.rd_data = rd_valid_q ? rdat : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy = state_q != IDLE;
  assign bus.sample_cnt = cnt_q;
  assign bus.ovf = ovf_q;
  assign bus.proto_err = perr_q;
endmodule
